// File: rtl/wb_bram_slave.sv
// Pipelined Wishbone block-RAM slave: byte-masked writes, fixed LATENCY-cycle ack/err, in-order responses.
// Stalls once MAX_PENDING requests are outstanding; dropping cyc discards every in-flight response.
module wb_bram_slave #(
    parameter int          AW          = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2,
    parameter int          MAX_PENDING = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        s_cyc_ena,
    input  logic        s_cyc_stb,
    input  logic        s_cyc_we,
    input  logic [31:0] s_cyc_adr,
    input  logic [31:0] s_cyc_dat,
    input  logic [3:0]  s_cyc_sel,
    output logic        s_cyc_rdy,
    output logic        s_ack,
    output logic        s_ack_rdy,
    output logic        s_err,
    output logic        s_err_rdy,
    output logic        s_stall,
    output logic        s_stall_rdy,
    output logic [31:0] s_idat
);

    localparam int PW = $clog2(MAX_PENDING + 1);

    typedef struct packed {
        logic        vld;
        logic        is_err;
        logic        is_rd;
        logic [31:0] dat;
    } rsp_t;

    logic [31:0]   mem_q [0:(1 << AW) - 1];
    rsp_t          pipe_q [LATENCY];
    rsp_t          slot_d;
    rsp_t          exit_s;
    logic [PW-1:0] pending_q;
    logic [PW-1:0] pending_d;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          accept;
    logic          rsp_vld;
    logic          unused_adr;

    assign word_idx   = s_cyc_adr[AW+1:2];
    assign in_range   = (s_cyc_adr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign unused_adr = ^s_cyc_adr[1:0];
    assign exit_s     = pipe_q[LATENCY-1];

    // A response is only visible while the bus cycle it belongs to is still open.
    assign rsp_vld = s_cyc_ena && exit_s.vld;
    assign s_stall = s_cyc_ena && (pending_q == PW'(MAX_PENDING)) && !rsp_vld;
    assign accept  = s_cyc_ena && s_cyc_stb && !s_stall && !RST;

    assign s_ack       = rsp_vld && !exit_s.is_err;
    assign s_err       = rsp_vld && exit_s.is_err;
    assign s_idat      = (s_ack && exit_s.is_rd) ? exit_s.dat : 32'h0;
    assign s_cyc_rdy   = !RST;
    assign s_ack_rdy   = 1'b1;
    assign s_err_rdy   = 1'b1;
    assign s_stall_rdy = 1'b1;

    always_ff @(posedge CLK) begin
        if (accept && in_range && s_cyc_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_cyc_sel[b]) begin
                    mem_q[word_idx][8*b +: 8] <= s_cyc_dat[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        slot_d        = '0;
        slot_d.vld    = accept;
        slot_d.is_err = accept && !in_range;
        slot_d.is_rd  = accept && !s_cyc_we;
        if (accept && in_range && !s_cyc_we) begin
            slot_d.dat = mem_q[word_idx];
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (accept && !rsp_vld) begin
            pending_d = pending_q + PW'(1);
        end else if (!accept && rsp_vld) begin
            pending_d = pending_q - PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || !s_cyc_ena) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            pipe_q[0] <= slot_d;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            pending_q <= pending_d;
        end
    end

endmodule
